// File: rtl/k_alu_mc.sv
// Multi-cycle ALU: single-cycle logic/arith ops, iterative shift-add multiply and restoring divide.
// Single-cycle ops complete one cycle after start; MUL/MULHU/DIVU/REMU take WIDTH+2 cycles.
module k_alu_mc #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [4:0]       sel,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic [WIDTH-1:0] res,
  output logic             busy,
  output logic             done,
  output logic             zero,
  output logic             dz,
  output logic             illegal
);
  localparam int SHW = $clog2(WIDTH);
  localparam logic [SHW:0] CNT_ONE  = {{SHW{1'b0}}, 1'b1};
  localparam logic [SHW:0] CNT_INIT = (SHW+1)'(WIDTH);

  typedef enum logic [1:0] {IDLE, RUN, FIN} state_t;

  state_t             state;
  logic               op_div;
  logic               op_hi;
  logic [WIDTH-1:0]   opb;
  logic [2*WIDTH-1:0] acc;
  logic [SHW:0]       cnt;

  logic [SHW-1:0]     sh;
  logic [WIDTH-1:0]   pop;
  logic [WIDTH-1:0]   imm_res;
  logic               imm_dz;
  logic               imm_ill;
  logic               is_multi;
  logic               go_run;

  assign sh       = B[SHW-1:0];
  assign is_multi = (sel[4:2] == 3'b100);
  assign go_run   = is_multi && !(sel[1] && (B == '0));

  always_comb begin
    pop = '0;
    for (int i = 0; i < WIDTH; i++) begin
      pop = pop + {{(WIDTH-1){1'b0}}, A[i]};
    end
  end

  always_comb begin
    imm_res = '0;
    imm_dz  = 1'b0;
    imm_ill = 1'b0;
    case (sel)
      5'd0:  imm_res = A + B;
      5'd1:  imm_res = A - B;
      5'd2:  imm_res = {{(WIDTH-1){1'b0}}, ($signed(A) < $signed(B))};
      5'd3:  imm_res = {{(WIDTH-1){1'b0}}, ($signed(A) > $signed(B))};
      5'd4:  imm_res = A & B;
      5'd5:  imm_res = A | B;
      5'd6:  imm_res = A ^ B;
      5'd7:  imm_res = ~A;
      5'd8:  imm_res = ~(A | B);
      5'd9:  imm_res = B << (WIDTH/2);
      5'd10: imm_res = A << sh;
      5'd11: imm_res = A >> sh;
      5'd12: imm_res = $unsigned($signed(A) >>> sh);
      5'd13: imm_res = A + WIDTH'(4);
      5'd14: imm_res = A - WIDTH'(4);
      5'd15: imm_res = pop;
      // Only reachable here for divide by zero; multiplies always go to RUN.
      5'd18: begin imm_res = '1; imm_dz = 1'b1; end
      5'd19: begin imm_res = A;  imm_dz = 1'b1; end
      5'd16, 5'd17: imm_res = '0;
      default: imm_ill = 1'b1;
    endcase
  end

  // One iteration of shift-add multiply (B in acc low half, product builds from the top)
  // or restoring divide (remainder in acc high half, dividend/quotient in low half).
  logic [WIDTH:0]     mul_sum;
  logic [WIDTH:0]     div_rs;
  logic [WIDTH:0]     div_diff;
  logic [2*WIDTH-1:0] acc_nxt;

  always_comb begin
    mul_sum  = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, opb} : '0);
    div_rs   = {acc[2*WIDTH-1:WIDTH], acc[WIDTH-1]};
    div_diff = div_rs - {1'b0, opb};
    if (!op_div)
      acc_nxt = {mul_sum, acc[WIDTH-1:1]};
    else if (div_diff[WIDTH])
      acc_nxt = {div_rs[WIDTH-1:0], acc[WIDTH-2:0], 1'b0};
    else
      acc_nxt = {div_diff[WIDTH-1:0], acc[WIDTH-2:0], 1'b1};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      res     <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
      zero    <= 1'b0;
      dz      <= 1'b0;
      illegal <= 1'b0;
      cnt     <= '0;
      acc     <= '0;
      opb     <= '0;
      op_div  <= 1'b0;
      op_hi   <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            if (go_run) begin
              op_div <= sel[1];
              op_hi  <= sel[0];
              opb    <= sel[1] ? B : A;
              acc    <= {{WIDTH{1'b0}}, (sel[1] ? A : B)};
              cnt    <= CNT_INIT;
              busy   <= 1'b1;
              state  <= RUN;
            end else begin
              res     <= imm_res;
              zero    <= (imm_res == '0);
              dz      <= imm_dz;
              illegal <= imm_ill;
              done    <= 1'b1;
            end
          end
        end
        RUN: begin
          acc <= acc_nxt;
          cnt <= cnt - CNT_ONE;
          if (cnt == CNT_ONE) state <= FIN;
        end
        FIN: begin
          res     <= op_hi ? acc[2*WIDTH-1:WIDTH] : acc[WIDTH-1:0];
          zero    <= ((op_hi ? acc[2*WIDTH-1:WIDTH] : acc[WIDTH-1:0]) == '0);
          dz      <= 1'b0;
          illegal <= 1'b0;
          busy    <= 1'b0;
          done    <= 1'b1;
          state   <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_k_alu_mc.sv
// Scoreboard bench for k_alu_mc: 32-bit instance checked by a decoupled monitor, 8-bit instance by direct checks.
module tb_k_alu_mc;
  localparam int W = 32;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          start;
  logic [4:0]    sel;
  logic [W-1:0]  a, b;
  logic [W-1:0]  res;
  logic          busy, done, zero, dz, illegal;

  logic          start8;
  logic [4:0]    sel8;
  logic [7:0]    a8, b8, res8;
  logic          busy8, done8, zero8, dz8, illegal8;

  int checks = 0;
  int errors = 0;
  int edge_cnt = 0;
  int busy_run = 0;

  typedef struct {
    logic [W-1:0] res;
    logic         zero;
    logic         dz;
    logic         ill;
    int           done_edge;
    logic         multi;
  } exp_t;

  exp_t sb[$];

  k_alu_mc #(.WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .sel(sel), .A(a), .B(b),
    .res(res), .busy(busy), .done(done), .zero(zero), .dz(dz), .illegal(illegal)
  );

  k_alu_mc #(.WIDTH(8)) dut8 (
    .clk(clk), .rst_n(rst_n), .start(start8), .sel(sel8), .A(a8), .B(b8),
    .res(res8), .busy(busy8), .done(done8), .zero(zero8), .dz(dz8), .illegal(illegal8)
  );

  always #5 clk = ~clk;
  always @(posedge clk) edge_cnt <= edge_cnt + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor: pops one expectation per done pulse.
  always @(negedge clk) begin
    if (!rst_n) begin
      busy_run = 0;
    end else begin
      if (busy) busy_run++;
      if (done) begin
        if (sb.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL spurious_done: got res=%0h expected no done", res);
        end else begin
          exp_t e;
          e = sb.pop_front();
          chk("res", res, e.res);
          chk("zero", zero, e.zero);
          chk("dz", dz, e.dz);
          chk("illegal", illegal, e.ill);
          chk("done_latency", edge_cnt, e.done_edge);
          if (e.multi) chk("busy_cycles", busy_run, W + 1);
        end
        busy_run = 0;
      end
    end
  end

  task automatic issue(input logic [4:0] s, input logic [W-1:0] av, input logic [W-1:0] bv,
                       input logic [W-1:0] er, input logic edz, input logic eill);
    exp_t e;
    int   guard;
    guard = 0;
    @(negedge clk);
    while (busy && guard < 200) begin
      @(negedge clk);
      guard++;
    end
    if (busy) begin
      checks++; errors++;
      $display("FAIL busy_timeout: got busy=1 expected 0");
    end
    e.res       = er;
    e.zero      = (er == '0);
    e.dz        = edz;
    e.ill       = eill;
    e.multi     = (s >= 5'd16 && s <= 5'd19) && !(s >= 5'd18 && bv == '0);
    e.done_edge = edge_cnt + 1 + (e.multi ? W + 1 : 0);
    sb.push_back(e);
    start = 1'b1; sel = s; a = av; b = bv;
    @(posedge clk);
    #1 start = 1'b0;
  endtask

  task automatic drain();
    int guard;
    guard = 0;
    while (sb.size() != 0 && guard < 300) begin
      @(negedge clk);
      guard++;
    end
    @(negedge clk);
    chk("scoreboard_drained", sb.size(), 0);
  endtask

  task automatic run8(input logic [4:0] s, input logic [7:0] av, input logic [7:0] bv,
                      input logic [7:0] er, input logic eill, input string name);
    int guard;
    @(negedge clk);
    start8 = 1'b1; sel8 = s; a8 = av; b8 = bv;
    @(posedge clk);
    #1 start8 = 1'b0;
    guard = 0;
    @(negedge clk);
    while (!done8 && guard < 20) begin
      @(negedge clk);
      guard++;
    end
    chk({name, "_done"}, done8, 1'b1);
    chk({name, "_res"}, res8, er);
    chk({name, "_illegal"}, illegal8, eill);
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; sel = '0; a = '0; b = '0;
    start8 = 1'b0; sel8 = '0; a8 = '0; b8 = '0;
    #3;
    chk("rst_res", res, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_zero", zero, 0);
    chk("rst_dz", dz, 0);
    chk("rst_illegal", illegal, 0);
    chk("rst_res8", res8, 0);
    @(negedge clk);
    rst_n = 1'b1;

    run8(5'd12, 8'h80, 8'h0B, 8'hF0, 1'b0, "w8_sra");
    run8(5'd15, 8'hFF, 8'h00, 8'h08, 1'b0, "w8_popcnt");
    run8(5'd25, 8'h12, 8'h34, 8'h00, 1'b1, "w8_illegal");
    run8(5'd16, 8'd15, 8'd17, 8'hFF, 1'b0, "w8_mul");
    run8(5'd18, 8'd200, 8'd9, 8'd22, 1'b0, "w8_divu");

    // Back-to-back single-cycle ops.
    issue(5'd1,  32'd5,        32'd7,        32'hFFFFFFFE, 0, 0);
    issue(5'd0,  32'hFFFFFFFF, 32'd1,        32'h0,        0, 0);
    issue(5'd2,  32'hFFFFFFFF, 32'd1,        32'd1,        0, 0);
    issue(5'd3,  32'hFFFFFFFF, 32'd1,        32'd0,        0, 0);
    issue(5'd4,  32'h0000F0F0, 32'h0000FF00, 32'h0000F000, 0, 0);
    issue(5'd5,  32'h0000F0F0, 32'h0000FF00, 32'h0000FFF0, 0, 0);
    issue(5'd6,  32'h0000F0F0, 32'h0000FF00, 32'h00000FF0, 0, 0);
    issue(5'd7,  32'h0000FFFF, 32'd0,        32'hFFFF0000, 0, 0);
    issue(5'd8,  32'h000000F0, 32'h0000000F, 32'hFFFFFF00, 0, 0);
    issue(5'd9,  32'd0,        32'h00001234, 32'h12340000, 0, 0);
    issue(5'd10, 32'd1,        32'h00000104, 32'h00000010, 0, 0);
    issue(5'd11, 32'h80000000, 32'd31,       32'd1,        0, 0);
    issue(5'd12, 32'h80000000, 32'd4,        32'hF8000000, 0, 0);
    issue(5'd13, 32'hFFFFFFFE, 32'd0,        32'd2,        0, 0);
    issue(5'd14, 32'd2,        32'd0,        32'hFFFFFFFE, 0, 0);
    issue(5'd15, 32'hF0F0000F, 32'd0,        32'd12,       0, 0);
    issue(5'd20, 32'd1,        32'd1,        32'd0,        0, 1);
    issue(5'd31, 32'd1,        32'd1,        32'd0,        0, 1);

    // Multi-cycle ops and divide-by-zero shortcut.
    issue(5'd16, 32'h00010000, 32'h00010000, 32'd0,        0, 0);
    issue(5'd17, 32'h00010000, 32'h00010000, 32'd1,        0, 0);
    issue(5'd16, 32'd7,        32'd6,        32'd42,       0, 0);
    issue(5'd17, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 0, 0);
    issue(5'd18, 32'd100,      32'd7,        32'd14,       0, 0);
    issue(5'd19, 32'd100,      32'd7,        32'd2,        0, 0);
    issue(5'd18, 32'd100,      32'd0,        32'hFFFFFFFF, 1, 0);
    issue(5'd19, 32'd55,       32'd0,        32'd55,       1, 0);
    issue(5'd18, 32'hFFFFFFFF, 32'd1,        32'hFFFFFFFF, 0, 0);
    issue(5'd19, 32'd7,        32'd9,        32'd7,        0, 0);

    // A start during a divide is dropped; operands changing mid-run must not matter.
    issue(5'd18, 32'd1000,     32'd3,        32'd333,      0, 0);
    repeat (5) @(negedge clk);
    start = 1'b1; sel = 5'd0; a = 32'd1; b = 32'd1;
    @(negedge clk);
    start = 1'b0;
    drain();

    // Reset in the middle of a run aborts it without a done pulse.
    issue(5'd0, 32'd20, 32'd22, 32'd42, 0, 0);
    drain();
    @(negedge clk);
    start = 1'b1; sel = 5'd19; a = 32'd1000; b = 32'd3;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (10) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("abort_busy", busy, 0);
    chk("abort_done", done, 0);
    chk("abort_res", res, 0);
    chk("abort_zero", zero, 0);
    @(negedge clk);
    rst_n = 1'b1;
    issue(5'd6, 32'hA5A5A5A5, 32'hFFFFFFFF, 32'h5A5A5A5A, 0, 0);
    repeat (60) @(negedge clk);
    drain();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/k_alu_mc.md
K_ALU_MC -- requirements
Module: k_alu_mc

Interface
REQ-001 Parameter WIDTH, default 32, operand and result width; SHALL be a power of two, minimum 8.
REQ-002 Localparam SHW = log2(WIDTH), the shift-amount width.
REQ-003 clk  input  1  sole clock; all state SHALL update on the rising edge.
REQ-004 rst_n  input  1  reset; asynchronous, active-low.
REQ-005 start  input  1  request strobe; sampled only while busy=0.
REQ-006 sel  input  5  opcode, captured with start.
REQ-007 A  input  WIDTH  operand A, captured with start.
REQ-008 B  input  WIDTH  operand B, captured with start.
REQ-009 res  output  WIDTH  registered result.
REQ-010 busy  output  1  high while a multi-cycle operation is in progress.
REQ-011 done  output  1  single-cycle pulse marking res valid.
REQ-012 zero  output  1  registered; set when res==0, updated together with done.
REQ-013 dz  output  1  divide-by-zero flag, updated with done.
REQ-014 illegal  output  1  unsupported-opcode flag, updated with done.

Function
REQ-015 Opcodes 0-15 are single-cycle: 0 A+B; 1 A-B; 2 signed A<B ? 1:0; 3 signed A>B ? 1:0; 4 A&B; 5 A|B; 6 A^B; 7 ~A; 8 ~(A|B); 9 B<<(WIDTH/2); 10 A<<B[SHW-1:0]; 11 logical A>>B[SHW-1:0]; 12 arithmetic A>>>B[SHW-1:0]; 13 A+4; 14 A-4; 15 popcount(A), zero-extended.
REQ-016 Opcodes 16-19 are multi-cycle: 16 MUL, low WIDTH bits of unsigned A*B; 17 MULHU, high WIDTH bits; 18 DIVU, unsigned A/B; 19 REMU, unsigned A%B.
REQ-017 Opcodes 20-31 are illegal: res=0, illegal=1, single-cycle timing.
REQ-018 Arithmetic wraps modulo 2^WIDTH; no carry or overflow outputs.
REQ-019 FSM states: IDLE, RUN, FIN.
REQ-020 IDLE, start=1, single-cycle or illegal opcode: result registered at the same edge; done=1 in the next cycle; state remains IDLE.
REQ-021 IDLE, start=1, opcode 16-19, B!=0 or opcode 16/17: operands latched; busy=1 from the next cycle; iteration counter loaded with WIDTH; state -> RUN.
REQ-022 RUN: one iteration per cycle. Multiply uses shift-add over a 2*WIDTH accumulator. Divide uses restoring shift-subtract.
REQ-023 RUN: counter decrements each cycle; at zero, state -> FIN.
REQ-024 FIN: res, zero and dz loaded; busy=0 and done=1 in the following cycle; state -> IDLE.
REQ-025 Multi-cycle latency: start accepted at edge N gives done high in cycle N+WIDTH+2; busy high for exactly WIDTH+1 cycles.
REQ-026 DIVU/REMU with B==0: single-cycle timing and dz=1; DIVU res = all ones; REMU res = A.
REQ-027 start while busy=1 SHALL be ignored, with no queuing.
REQ-028 start may be asserted in the done cycle and is accepted (back-to-back operation).
REQ-029 res, zero, dz and illegal SHALL hold their values until the next completion; done is high exactly one cycle per accepted start.
REQ-030 sel, A and B may change after acceptance without affecting the operation in progress.
REQ-031 Shift amounts use only B[SHW-1:0]; upper bits of B are ignored.

Reset
REQ-032 rst_n=0 SHALL immediately force the state to IDLE and clear res, busy, done, zero, dz, illegal and the counter, regardless of clock.
REQ-033 After reset, zero=0, not 1, until the first completion.
REQ-034 Reset during RUN aborts the operation; no done pulse is produced for it.
REQ-035 The first start SHALL be accepted on the first rising edge with rst_n=1.

Verification
REQ-036 WIDTH=32, sel=1, A=5, B=7 -> one cycle later done=1, res=0xFFFFFFFE, zero=0.
REQ-037 WIDTH=32, sel=16, A=0x10000, B=0x10000, then sel=17 -> MUL res=0, zero=1; MULHU res=1; each done at N+34; busy high 33 cycles.
REQ-038 sel=18, A=100, B=7, then sel=19 -> DIVU res=14, REMU res=2; sel=18, B=0 -> done at N+1, res=0xFFFFFFFF, dz=1.
REQ-039 During a DIVU, pulse start with sel=0 -> ignored; exactly one done, carrying the DIVU result.
REQ-040 Drop rst_n mid-RUN at cycle 10 -> busy, done and res are 0 asynchronously; no later done appears.
REQ-041 WIDTH=8: sel=12, A=0x80, B=0x0B (shift 3) -> res=0xF0; sel=15, A=0xFF -> res=8; sel=25 -> illegal=1, res=0.
